// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped switch/LED I/O block.
//   Input channels (switches) are two-flop synchronized and readable at
//   BASE_IN+k. Output channels (LEDs) are read/write registers at
//   BASE_OUT+k. Reads return data one cycle after issue with a one-cycle
//   rvalid pulse. rdata is zero whenever rvalid is low.
//   Optional feature macro: MMIO_EVENT_CAPTURE_EN adds a sticky rising-edge
//   register per input channel at BASE_IN+N_IN+k, cleared by reading it.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   mem_cmd    00 none, 01 read, 10 write, 11 none
//   mem_addr   CPU address
//   wdata      CPU write data
//   in_ports   asynchronous switch inputs, channel k at [k*IN_W +: IN_W]
//   hit        combinational: active command decodes to this block
//   rdata      registered read data
//   rvalid     registered read-data-valid pulse
//   out_ports  registered LED outputs, channel k at [k*OUT_W +: OUT_W]
module mmio_io_ctrl #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned N_IN     = 2,
  parameter int unsigned IN_W     = 8,
  parameter int unsigned N_OUT    = 2,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned BASE_IN  = 'h140,
  parameter int unsigned BASE_OUT = 'h100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mem_cmd,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [N_IN*IN_W-1:0]    in_ports,
  output logic                    hit,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rvalid,
  output logic [N_OUT*OUT_W-1:0]  out_ports
);

  localparam logic [1:0] CMD_RD = 2'b01;
  localparam logic [1:0] CMD_WR = 2'b10;

  logic                   is_rd;
  logic                   is_wr;
  logic                   map_hit;
  logic                   rd_fire;
  logic [DATA_W-1:0]      rd_mux;
  logic [N_OUT-1:0]       out_we;
  logic [N_IN*IN_W-1:0]   in_meta;
  logic [N_IN*IN_W-1:0]   in_sync;

  assign is_rd   = (mem_cmd == CMD_RD);
  assign is_wr   = (mem_cmd == CMD_WR);
  assign hit     = map_hit & (is_rd | is_wr);
  assign rd_fire = map_hit & is_rd;

  // Two-flop synchronizer for the asynchronous switch inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_meta <= '0;
      in_sync <= '0;
    end else begin
      in_meta <= in_ports;
      in_sync <= in_meta;
    end
  end

`ifdef MMIO_EVENT_CAPTURE_EN
  logic [N_IN*IN_W-1:0]   in_sync_d;
  logic [N_IN*IN_W-1:0]   ev_q;
  logic [N_IN*IN_W-1:0]   ev_clr_mask;

  // Sticky rising-edge capture; a new edge in the clearing cycle survives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_sync_d <= '0;
      ev_q      <= '0;
    end else begin
      in_sync_d <= in_sync;
      ev_q      <= (ev_q & ~ev_clr_mask) | (in_sync & ~in_sync_d);
    end
  end
`endif

  // Address decode, read mux and write enables
  always_comb begin
    map_hit = 1'b0;
    rd_mux  = '0;
    out_we  = '0;
`ifdef MMIO_EVENT_CAPTURE_EN
    ev_clr_mask = '0;
`endif
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (mem_addr == ADDR_W'(BASE_IN + k)) begin
        map_hit = 1'b1;
        rd_mux  = DATA_W'(in_sync[k*IN_W +: IN_W]);
      end
    end
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (mem_addr == ADDR_W'(BASE_OUT + k)) begin
        map_hit   = 1'b1;
        rd_mux    = DATA_W'(out_ports[k*OUT_W +: OUT_W]);
        out_we[k] = is_wr;
      end
    end
`ifdef MMIO_EVENT_CAPTURE_EN
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (mem_addr == ADDR_W'(BASE_IN + N_IN + k)) begin
        map_hit = 1'b1;
        rd_mux  = DATA_W'(ev_q[k*IN_W +: IN_W]);
        ev_clr_mask[k*IN_W +: IN_W] = {IN_W{is_rd}};
      end
    end
`endif
  end

  // Output (LED) registers; only the low OUT_W bits of wdata are stored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_ports <= '0;
    end else begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (out_we[k]) begin
          out_ports[k*OUT_W +: OUT_W] <= wdata[OUT_W-1:0];
        end
      end
    end
  end

  // Read response: one cycle after issue, rdata forced to zero when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= rd_fire;
      rdata  <= rd_fire ? rd_mux : '0;
    end
  end

  // Upper write-data bits are intentionally ignored
  if (OUT_W < DATA_W) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[DATA_W-1:OUT_W];
  end

endmodule
